// File: rtl/siren_pattern_generator.sv
// Purpose: square-wave siren driver (WAIL/YELP/HILO) plus counted CHIRP bursts for the alarm speaker.
// Latency: registered; a request is taken on the next clock edge, first toggle D+1 edges later.
// Backpressure: none; chirpStart while busy is dropped, siren preempts any chirp burst.
module siren_pattern_generator #(
  parameter int SWEEP_WIDTH   = 27,
  parameter int RAMP_BITS     = 7,
  parameter int DIV_WIDTH     = 18,
  parameter int BASE_DIV      = 65536,
  parameter int RAMP_SHIFT    = 9,
  parameter int YELP_SHIFT    = 3,
  parameter int HI_DIV        = 70000,
  parameter int LO_DIV        = 110000,
  parameter int CHIRP_ON_CYC  = 5000000,
  parameter int CHIRP_OFF_CYC = 5000000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       siren,
  input  logic [1:0] mode,
  input  logic       chirpStart,
  input  logic [3:0] chirpCount,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  localparam int PH_MAX = (CHIRP_ON_CYC > CHIRP_OFF_CYC) ? CHIRP_ON_CYC : CHIRP_OFF_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [31:0]          RAMP_MAX  = (32'd1 << RAMP_BITS) - 32'd1;
  // tone 0 gives the all-ones ramp, i.e. the longest sweep half-period
  localparam logic [DIV_WIDTH-1:0] SWEEP0_DIV = DIV_WIDTH'(BASE_DIV + (RAMP_MAX << RAMP_SHIFT));
  localparam logic [DIV_WIDTH-1:0] HI_D       = DIV_WIDTH'(HI_DIV);
  localparam logic [DIV_WIDTH-1:0] LO_D       = DIV_WIDTH'(LO_DIV);
  localparam logic [PH_W-1:0]      ON_LAST    = PH_W'(CHIRP_ON_CYC - 1);
  localparam logic [PH_W-1:0]      OFF_LAST   = PH_W'(CHIRP_OFF_CYC - 1);

  typedef enum logic [1:0] {IDLE, SIREN, CHIRP_ON, CHIRP_OFF} state_t;

  state_t                 state, state_n;
  logic [SWEEP_WIDTH-1:0] tone, tone_n;
  logic [DIV_WIDTH-1:0]   counter, counter_n;
  logic [1:0]             mode_q, mode_n;
  logic [3:0]             remaining, remaining_n;
  logic [PH_W-1:0]        phase, phase_n;
  logic                   speaker_n, done_n;

  logic [RAMP_BITS-1:0]   ramp;
  logic [DIV_WIDTH-1:0]   sweep_div, siren_div, idle_div;

  // divider for the latched siren pattern at the current tone, and the idle reload for the mode input
  always_comb begin
    ramp      = (mode_q == 2'd1) ? ~tone[SWEEP_WIDTH-2-YELP_SHIFT -: RAMP_BITS]
                                 : ~tone[SWEEP_WIDTH-2 -: RAMP_BITS];
    sweep_div = DIV_WIDTH'(BASE_DIV + (32'(ramp) << RAMP_SHIFT));
    siren_div = (mode_q == 2'd2) ? (tone[SWEEP_WIDTH-2] ? LO_D : HI_D) : sweep_div;
    idle_div  = (mode == 2'd2) ? HI_D : SWEEP0_DIV;
  end

  // next-state and datapath update for the pattern FSM
  always_comb begin
    state_n     = state;
    tone_n      = tone;
    counter_n   = counter;
    mode_n      = mode_q;
    remaining_n = remaining;
    phase_n     = phase;
    speaker_n   = speaker;
    done_n      = 1'b0;
    case (state)
      IDLE: begin
        speaker_n = 1'b0;
        tone_n    = '0;
        counter_n = idle_div;
        phase_n   = '0;
        if (siren) begin
          state_n = SIREN;
          mode_n  = mode;
        end else if (chirpStart) begin
          state_n     = CHIRP_ON;
          remaining_n = (chirpCount == 4'd0) ? 4'd1 : chirpCount;
          counter_n   = HI_D;
        end
      end
      SIREN: begin
        if (!siren) begin
          state_n   = IDLE;
          speaker_n = 1'b0;
          tone_n    = '0;
          counter_n = idle_div;
        end else begin
          tone_n = tone + 1'b1;
          if (counter != '0) begin
            counter_n = counter - 1'b1;
          end else begin
            counter_n = siren_div;
            speaker_n = ~speaker;
          end
        end
      end
      CHIRP_ON: begin
        if (siren) begin
          state_n   = SIREN;
          mode_n    = mode;
          tone_n    = '0;
          counter_n = idle_div;
          speaker_n = 1'b0;
          phase_n   = '0;
        end else if (phase == ON_LAST) begin
          speaker_n = 1'b0;
          phase_n   = '0;
          if (remaining > 4'd1) begin
            state_n     = CHIRP_OFF;
            remaining_n = remaining - 4'd1;
            counter_n   = HI_D;
          end else begin
            state_n   = IDLE;
            done_n    = 1'b1;
            counter_n = idle_div;
          end
        end else begin
          phase_n = phase + 1'b1;
          tone_n  = tone + 1'b1;
          if (counter != '0) begin
            counter_n = counter - 1'b1;
          end else begin
            counter_n = HI_D;
            speaker_n = ~speaker;
          end
        end
      end
      CHIRP_OFF: begin
        speaker_n = 1'b0;
        if (siren) begin
          state_n   = SIREN;
          mode_n    = mode;
          tone_n    = '0;
          counter_n = idle_div;
          phase_n   = '0;
        end else if (phase == OFF_LAST) begin
          state_n = CHIRP_ON;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= IDLE;
      tone      <= '0;
      counter   <= idle_div;
      mode_q    <= 2'd0;
      remaining <= 4'd0;
      phase     <= '0;
      speaker   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      tone      <= tone_n;
      counter   <= counter_n;
      mode_q    <= mode_n;
      remaining <= remaining_n;
      phase     <= phase_n;
      speaker   <= speaker_n;
      done      <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_siren_pattern_generator.sv
// Purpose: randomized check of siren_pattern_generator against a toggle-schedule reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is driven open-loop.
module tb_siren_pattern_generator;

  localparam int ON  = 10;
  localparam int OFF = 6;
  localparam int P   = ON + OFF;
  localparam int HI  = 2;
  localparam int LO  = 5;

  logic       clock = 1'b0;
  logic       resetN, siren, chirpStart;
  logic [1:0] mode;
  logic [3:0] chirpCount;
  logic       speaker, busy, done;

  int errors = 0;
  int checks = 0;

  siren_pattern_generator #(
    .SWEEP_WIDTH(8), .RAMP_BITS(2), .DIV_WIDTH(18), .BASE_DIV(3), .RAMP_SHIFT(0),
    .YELP_SHIFT(3), .HI_DIV(HI), .LO_DIV(LO), .CHIRP_ON_CYC(ON), .CHIRP_OFF_CYC(OFF)
  ) dut (
    .clock(clock), .resetN(resetN), .siren(siren), .mode(mode),
    .chirpStart(chirpStart), .chirpCount(chirpCount),
    .speaker(speaker), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic es, input logic eb, input logic ed);
    check({tag, "/speaker"}, {31'd0, speaker}, {31'd0, es});
    check({tag, "/busy"},    {31'd0, busy},    {31'd0, eb});
    check({tag, "/done"},    {31'd0, done},    {31'd0, ed});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // half-period minus one for a siren pattern at a given tone value (8-bit tone)
  function automatic int div_ref(input int m, input int tone);
    int t;
    t = tone % 256;
    if (m == 2) return ((t / 64) % 2 == 1) ? LO : HI;
    if (m == 1) return 3 + (3 - (t / 4) % 4);
    return 3 + (3 - (t / 32) % 4);
  endfunction

  // speaker level n edges after siren entry: toggles happen at a schedule where each
  // gap is one more than the divider seen at the previous toggle (tone = edge - 1)
  function automatic logic siren_spk(input int m, input int n);
    int   t;
    logic s;
    s = 1'b0;
    t = div_ref(m, 0) + 1;
    while (t <= n) begin
      s = ~s;
      t = t + div_ref(m, t - 1) + 1;
    end
    return s;
  endfunction

  // expected outputs n edges after a burst of nc chirps was accepted
  task automatic chirp_ref(input int nc, input int n, output logic s, output logic b, output logic d);
    int k, j;
    k = n / P;
    j = n % P;
    s = 1'b0; b = 1'b0; d = 1'b0;
    if (k < nc - 1 || (k == nc - 1 && j < ON)) begin
      b = 1'b1;
      if (j < ON) s = ((j / (HI + 1)) % 2) == 1;
    end else if (k == nc - 1 && j == ON) begin
      d = 1'b1;
    end
  endtask

  task automatic run_siren(input int m, input int len, input bit chg, input bit with_start);
    siren      = 1'b1;
    mode       = m[1:0];
    chirpStart = with_start;
    chirpCount = 4'($urandom);
    step();
    chirpStart = 1'b0;
    check_outs("siren_entry", 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= len; n++) begin
      if (chg && n == len / 2) mode = 2'($urandom_range(0, 3));
      step();
      check_outs($sformatf("siren_m%0d_n%0d", m, n), siren_spk(m, n), 1'b1, 1'b0);
    end
    siren = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    step();
    check_outs("siren_off", 1'b0, 1'b0, 1'b0);
    step();
    check_outs("idle_after_siren", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_chirp(input int cnt, input int abort_at, input int rst_at, input bit noise);
    int   nc, last;
    logic es, eb, ed;
    nc   = (cnt == 0) ? 1 : cnt;
    last = (nc - 1) * P + ON + 2;
    siren      = 1'b0;
    chirpCount = cnt[3:0];
    chirpStart = 1'b1;
    step();
    chirpStart = 1'b0;
    chirpCount = 4'($urandom);
    check_outs("chirp_entry", 1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= last; n++) begin
      if (n == abort_at) begin
        run_siren($urandom_range(0, 3), 30, 1'b0, 1'b0);
        return;
      end
      if (n == rst_at) begin
        resetN = 1'b0;
        step();
        check_outs("reset_mid_chirp", 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        repeat (3) begin
          step();
          check_outs("after_mid_reset", 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      if (noise && n <= (nc - 1) * P + ON) begin
        chirpStart = 1'($urandom_range(0, 1));
        chirpCount = 4'($urandom);
      end
      step();
      chirpStart = 1'b0;
      chirp_ref(nc, n, es, eb, ed);
      check_outs($sformatf("chirp_c%0d_n%0d", cnt, n), es, eb, ed);
    end
  endtask

  initial begin
    resetN     = 1'b0;
    siren      = 1'b1;
    mode       = 2'd0;
    chirpStart = 1'b0;
    chirpCount = 4'd0;
    repeat (4) begin
      step();
      check_outs("reset", 1'b0, 1'b0, 1'b0);
    end
    resetN = 1'b1;
    siren  = 1'b0;
    step();
    check_outs("idle", 1'b0, 1'b0, 1'b0);

    run_siren(0, 160, 1'b0, 1'b0);                 // WAIL, first toggle at edge 7
    run_siren(2, 200, 1'b1, 1'b0);                 // HILO with ignored mode change
    run_siren(1, 120, 1'b1, 1'b1);                 // YELP, siren wins over chirpStart
    run_siren(3, 60,  1'b0, 1'b0);                 // reserved mode behaves as WAIL
    repeat (3) run_siren($urandom_range(0, 3), $urandom_range(20, 150), 1'($urandom_range(0, 1)), 1'b0);

    run_chirp(2, -1, -1, 1'b0);                    // two chirps, done pulse
    run_chirp(3, $urandom_range(ON + 1, P), -1, 1'b0); // abort in CHIRP_OFF
    run_chirp(0, -1, -1, 1'b1);                    // count 0 -> one chirp, extra starts ignored
    run_chirp(3, -1, $urandom_range(2, P + ON), 1'b0); // reset mid-burst
    repeat (3) run_chirp($urandom_range(0, 4), -1, -1, 1'b1);

    step();
    check_outs("final_idle", 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
